// File: rtl/button_conditioner.sv
// Purpose : per-channel synchronise, debounce and rise/fall edge pulses for raw button pins.
// Latency : raw change captured at edge k appears on stable/rise/fall at edge k+SYNC_STAGES-1+DEBOUNCE_CYCLES.
// Backpress: none; free-running, every output is a registered level or one-cycle pulse.
// Build option: define BUTTON_REPEAT_EN to build the auto-repeat counters driving rpt;
// without it rpt is tied to 0 and REPEAT_DELAY/REPEAT_PERIOD only feed the parameter checks.

module button_conditioner #(
  parameter int N_CH            = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] stable,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] rpt
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1 before the level is accepted.
  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Reject configurations the logic below cannot honour.
  if (N_CH < 1) begin : g_bad_n_ch
    $error("button_conditioner: N_CH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("button_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  // Stage j of the synchroniser holds all channels; the last stage is the usable level.
  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] s;
  logic [CW-1:0]   cnt_q  [N_CH];
  logic [N_CH-1:0] flip;

  // Shift raw pins through the synchroniser chain; reset clears every stage.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        sync_q[j] <= '0;
      end
    end else begin
      sync_q[0] <= button;
      for (int j = 1; j < SYNC_STAGES; j++) begin
        sync_q[j] <= sync_q[j-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A channel flips when its synchronised level has disagreed with stable for the full window.
  always_comb begin
    flip = '0;
    for (int i = 0; i < N_CH; i++) begin
      flip[i] = (s[i] != stable[i]) && (cnt_q[i] == CNT_LAST);
    end
  end

  // Per-channel qualification counter, accepted level and registered edge pulses.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
      stable <= '0;
      rise   <= '0;
      fall   <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (s[i] != stable[i]) begin
          if (flip[i]) begin
            stable[i] <= s[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i]  <= cnt_q[i] + CW'(1);
          end
        end else begin
          // Any agreement restarts qualification, so short glitches never accumulate.
          cnt_q[i] <= '0;
        end
      end
      rise <= flip & s;
      fall <= flip & ~s;
    end
  end

`ifdef BUTTON_REPEAT_EN
  // rcnt runs 0..DELAY+PERIOD-1; on reaching DELAY+PERIOD it folds back to DELAY,
  // so after the first pulse it cycles through exactly one period and never wraps to 0.
  localparam int             RPT_TOP    = REPEAT_DELAY + REPEAT_PERIOD;
  localparam int             RW         = $clog2(RPT_TOP + 1);
  localparam logic [RW-1:0]  RCNT_DELAY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0]  RCNT_TOP   = RW'(RPT_TOP);

  logic [RW-1:0] rcnt_q   [N_CH];
  logic [RW-1:0] rcnt_inc [N_CH];

  // Next count value per channel, shared by the compare and the update.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      rcnt_inc[i] = rcnt_q[i] + RW'(1);
    end
  end

  // Repeat timer: idle while released or on any edge cycle, so rpt never lands on rise/fall.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < N_CH; i++) begin
        rcnt_q[i] <= '0;
      end
      rpt <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!stable[i] || flip[i]) begin
          rcnt_q[i] <= '0;
          rpt[i]    <= 1'b0;
        end else if (rcnt_inc[i] == RCNT_TOP) begin
          rcnt_q[i] <= RCNT_DELAY;
          rpt[i]    <= 1'b1;
        end else begin
          rcnt_q[i] <= rcnt_inc[i];
          rpt[i]    <= (rcnt_inc[i] == RCNT_DELAY);
        end
      end
    end
  end
`else
  assign rpt = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with default parameters.
// Table rows are applied one per clock; multi-cycle corners (reset, mid-debounce
// reset, long hold with repeat) are hand-written loops.

module tb_button_conditioner;

  logic       clk;
  logic       n_rst;
  logic [4:0] button;
  logic [4:0] stable;
  logic [4:0] rise;
  logic [4:0] fall;
  logic [4:0] rpt;

  int n_cmp = 0;
  int n_bad = 0;

  button_conditioner #(
    .N_CH(5), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(16), .REPEAT_PERIOD(8)
  ) dut (
    .clk(clk), .n_rst(n_rst), .button(button),
    .stable(stable), .rise(rise), .fall(fall), .rpt(rpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] btn;
    logic [4:0] st;
    logic [4:0] ri;
    logic [4:0] fa;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [4:0] b, input logic [4:0] st,
                     input logic [4:0] ri, input logic [4:0] fa);
    vec_t v;
    v.btn = b; v.st = st; v.ri = ri; v.fa = fa;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- table fill ----------------
    // Starts from stable=11111 with all buttons held.
    // A: all released; fall on row 5 (capture edge + 5).
    for (int r = 0; r < 7; r++)
      add(5'b00000, (r < 5) ? 5'b11111 : 5'b00000, 5'b00000,
          (r == 5) ? 5'b11111 : 5'b00000);
    // B: ch2 high 3 cycles -> rejected.
    for (int r = 0; r < 9; r++)
      add((r < 3) ? 5'b00100 : 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    // C: ch2 high 4 cycles -> rise at 5, fall at 9.
    for (int r = 0; r < 11; r++)
      add((r < 4) ? 5'b00100 : 5'b00000,
          (r >= 5 && r < 9) ? 5'b00100 : 5'b00000,
          (r == 5) ? 5'b00100 : 5'b00000,
          (r == 9) ? 5'b00100 : 5'b00000);
    // D: ch0 held 8 cycles -> rise at 5, fall at 13.
    for (int r = 0; r < 15; r++)
      add((r < 8) ? 5'b00001 : 5'b00000,
          (r >= 5 && r < 13) ? 5'b00001 : 5'b00000,
          (r == 5) ? 5'b00001 : 5'b00000,
          (r == 13) ? 5'b00001 : 5'b00000);
    // E: ch1+ch3 high rows 0..9 while ch0 toggles every cycle.
    for (int r = 0; r < 18; r++)
      add(((r < 10) ? 5'b01010 : 5'b00000) | ((r % 2 == 0) ? 5'b00001 : 5'b00000),
          (r >= 5 && r < 15) ? 5'b01010 : 5'b00000,
          (r == 5) ? 5'b01010 : 5'b00000,
          (r == 15) ? 5'b01010 : 5'b00000);

    // ---------------- reset with all buttons held ----------------
    n_rst  = 1'b1;
    button = 5'b11111;
    #2 n_rst = 1'b0;
    repeat (3) tick();
    check("rst_stable", 0, stable, 5'b00000);
    check("rst_rise",   0, rise,   5'b00000);
    check("rst_fall",   0, fall,   5'b00000);
    check("rst_rpt",    0, rpt,    5'b00000);
    n_rst = 1'b1;
    // cyc 0 is the capture edge; rise for all channels on cyc 5.
    for (int c = 0; c < 8; c++) begin
      tick();
      check("rel_rise",   c, rise,   (c == 5) ? 5'b11111 : 5'b00000);
      check("rel_stable", c, stable, (c >= 5) ? 5'b11111 : 5'b00000);
      check("rel_fall",   c, fall,   5'b00000);
    end

    // ---------------- table ----------------
    for (int k = 0; k < tbl.size(); k++) begin
      button = tbl[k].btn;
      tick();
      check("tbl_stable", k, stable, tbl[k].st);
      check("tbl_rise",   k, rise,   tbl[k].ri);
      check("tbl_fall",   k, fall,   tbl[k].fa);
      check("tbl_rpt",    k, rpt,    5'b00000);
    end

    // ---------------- reset in the middle of ch4 debounce ----------------
    button = 5'b10000;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("md_pre_rise", c, rise, 5'b00000);
    end
    // ch4 counter now at 2.
    n_rst = 1'b0;
    #1;
    check("md_rst_stable", 0, stable, 5'b00000);
    check("md_rst_rise",   0, rise,   5'b00000);
    repeat (2) tick();
    check("md_rst_stable", 1, stable, 5'b00000);
    check("md_rst_rise",   1, rise,   5'b00000);
    n_rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("md_rise",   c, rise,   (c == 5) ? 5'b10000 : 5'b00000);
      check("md_stable", c, stable, (c >= 5) ? 5'b10000 : 5'b00000);
    end
    button = 5'b00000;
    for (int c = 0; c < 7; c++) begin
      tick();
      check("md_fall",   c, fall,   (c == 5) ? 5'b10000 : 5'b00000);
      check("md_stable2", c, stable, (c < 5) ? 5'b10000 : 5'b00000);
    end

    // ---------------- long hold on ch0 (repeat train when built) ----------------
    // rise at 5, rpt at 21/29/37, release at 40 -> fall at 45 (45 would
    // otherwise be a repeat slot and must stay quiet).
    for (int r = 0; r < 61; r++) begin
      logic [4:0] exp_rpt;
      button = (r < 40) ? 5'b00001 : 5'b00000;
      tick();
      exp_rpt = 5'b00000;
`ifdef BUTTON_REPEAT_EN
      if (r == 21 || r == 29 || r == 37) exp_rpt = 5'b00001;
`endif
      check("hold_stable", r, stable, (r >= 5 && r < 45) ? 5'b00001 : 5'b00000);
      check("hold_rise",   r, rise,   (r == 5) ? 5'b00001 : 5'b00000);
      check("hold_fall",   r, fall,   (r == 45) ? 5'b00001 : 5'b00000);
      check("hold_rpt",    r, rpt,    exp_rpt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
